// File: rtl/odd_even_sort_engine.sv
// odd_even_sort_engine: buffers a block of N unsigned words, sorts them with
// N odd-even transposition phases (one phase per clock, all compare-exchange
// decisions of a phase in parallel), then streams them out smallest first.
// N must be even and at least 2. Reset is synchronous and active-high.
module odd_even_sort_engine #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy
);

    localparam int CW = $clog2(N) + 1;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   elem [N];
    logic [W-1:0]   phase_next [N];
    logic [CW-1:0]  cnt;
    logic           last_cnt;
    logic           in_fire;
    logic           out_fire;

    assign last_cnt = (cnt == CW'(N - 1));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Borrow-chain comparator: borrow-out of (x - y) with borrow-in 0,
    // which is 1 exactly when x < y as unsigned numbers.
    function automatic logic borrow_lt(input logic [W-1:0] x, input logic [W-1:0] y);
        logic b;
        b = 1'b0;
        for (int i = 0; i < W; i++) begin
            b = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b);
        end
        return b;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create ordering races.
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: LOAD -> SORT after N words, SORT -> DRAIN after N
    // phases, DRAIN -> LOAD after N output handshakes.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            S_LOAD:  if (in_fire && last_cnt)  state_next = S_SORT;
            S_SORT:  if (last_cnt)             state_next = S_DRAIN;
            S_DRAIN: if (out_fire && last_cnt) state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    // Output decode from the current state; out_data reads 0 outside DRAIN.
    always_comb begin
        in_ready  = (state == S_LOAD);
        busy      = (state == S_SORT) || (state == S_DRAIN);
        out_valid = (state == S_DRAIN);
        out_data  = (state == S_DRAIN) ? elem[0] : '0;
    end

    // One transposition phase: even phases pair (0,1),(2,3)..., odd phases
    // pair (1,2),(3,4)... leaving the end words untouched. Equal words hold.
    always_comb begin
        phase_next = elem;
        if (!cnt[0]) begin
            for (int a = 0; a < N; a += 2) begin
                if (borrow_lt(elem[a+1], elem[a])) begin
                    phase_next[a]   = elem[a+1];
                    phase_next[a+1] = elem[a];
                end
            end
        end else begin
            for (int a = 1; a < N - 1; a += 2) begin
                if (borrow_lt(elem[a+1], elem[a])) begin
                    phase_next[a]   = elem[a+1];
                    phase_next[a+1] = elem[a];
                end
            end
        end
    end

    // Datapath: word buffer and the shared load/phase/drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            // NOTE: the buffer is cleared on reset on purpose, so a discarded
            // block can never leak stale words into a later one.
            for (int i = 0; i < N; i++) begin
                elem[i] <= '0;
            end
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        elem[cnt[IW-1:0]] <= in_data;
                        cnt <= last_cnt ? '0 : cnt + CW'(1);
                    end
                end
                S_SORT: begin
                    elem <= phase_next;
                    cnt  <= last_cnt ? '0 : cnt + CW'(1);
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        for (int i = 0; i < N - 1; i++) begin
                            elem[i] <= elem[i+1];
                        end
                        elem[N-1] <= '0;
                        cnt <= last_cnt ? '0 : cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_odd_even_sort_engine.sv
// Directed testbench for odd_even_sort_engine (N=8, W=8). Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
module tb_odd_even_sort_engine;

    localparam int N = 8;
    localparam int W = 8;
    localparam int BUDGET = 64;

    typedef logic [W-1:0] block_t [N];

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    odd_even_sort_engine #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_bit({tag, "_in_ready"}, in_ready, 1'b1);
        check_bit({tag, "_out_valid"}, out_valid, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_word({tag, "_out_data"}, out_data, 8'h00);
    endtask

    // Offer each word until accepted; optional idle gaps between words.
    task automatic load_block(input block_t blk, input bit gaps, input string tag);
        int budget;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            in_valid = 1'b1;
            in_data  = blk[i];
            budget   = 0;
            while (!in_ready && budget < BUDGET) begin
                step();
                budget++;
            end
            check_bit({tag, "_load_ready"}, in_ready, 1'b1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int budget;
        budget = 0;
        while (!out_valid && budget < BUDGET) begin
            step();
            budget++;
        end
        check_bit({tag, "_out_valid"}, out_valid, 1'b1);
    endtask

    // Accept N words, comparing each against the expected ascending block.
    task automatic drain_check(input block_t exp, input bit random_ready, input string tag);
        logic [W-1:0] held;
        for (int i = 0; i < N; i++) begin
            out_ready = random_ready ? 1'b0 : 1'b1;
            wait_out(tag);
            if (random_ready) begin
                repeat ($urandom_range(0, 2)) begin
                    held = out_data;
                    step();
                    check_word({tag, "_stable"}, out_data, held);
                    check_bit({tag, "_stall_valid"}, out_valid, 1'b1);
                    check_bit({tag, "_stall_in_ready"}, in_ready, 1'b0);
                end
            end
            out_ready = 1'b1;
            check_word($sformatf("%s_out%0d", tag, i), out_data, exp[i]);
            check_bit({tag, "_drain_in_ready"}, in_ready, 1'b0);
            step();
        end
        out_ready = 1'b0;
        check_bit({tag, "_end_in_ready"}, in_ready, 1'b1);
        check_bit({tag, "_end_out_valid"}, out_valid, 1'b0);
        check_bit({tag, "_end_busy"}, busy, 1'b0);
    endtask

    initial begin
        block_t blk_rev, blk_ext, blk_sorted, blk_bp, blk_mix, blk_a, blk_b;
        block_t exp_asc, exp_ext, exp_bp, exp_mix, exp_a, exp_b;

        blk_rev    = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        blk_sorted = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_asc    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        blk_ext    = '{8'hFF, 8'h00, 8'h80, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h01};
        exp_ext    = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF};
        blk_bp     = '{8'h05, 8'h03, 8'h09, 8'h01, 8'h07, 8'h02, 8'h08, 8'h04};
        exp_bp     = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h09};
        blk_mix    = '{8'h55, 8'h11, 8'h99, 8'h33, 8'h77, 8'h22, 8'h88, 8'h44};
        exp_mix    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77, 8'h88, 8'h99};
        blk_a      = '{8'h03, 8'h01, 8'h04, 8'h01, 8'h05, 8'h09, 8'h02, 8'h06};
        exp_a      = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h09};
        blk_b      = '{8'h20, 8'hE0, 8'h00, 8'hFF, 8'h40, 8'h40, 8'h10, 8'hC0};
        exp_b      = '{8'h00, 8'h10, 8'h20, 8'h40, 8'h40, 8'hC0, 8'hE0, 8'hFF};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();

        // Reset state.
        apply_reset("reset");

        // 1. Reverse order, with exact SORT latency.
        out_ready = 1'b1;
        load_block(blk_rev, 1'b0, "rev");
        check_bit("rev_sort_busy", busy, 1'b1);
        check_bit("rev_sort_in_ready", in_ready, 1'b0);
        for (int k = 1; k <= N; k++) begin
            step();
            check_bit($sformatf("rev_latency_%0d", k), out_valid, (k == N));
            check_bit("rev_sort_in_ready", in_ready, 1'b0);
        end
        drain_check(exp_asc, 1'b0, "rev");

        // 2. Duplicates and extremes.
        load_block(blk_ext, 1'b0, "ext");
        drain_check(exp_ext, 1'b0, "ext");

        // 3. Already sorted input.
        load_block(blk_sorted, 1'b0, "sorted");
        drain_check(exp_asc, 1'b0, "sorted");

        // 4. Input gaps and random output backpressure.
        load_block(blk_bp, 1'b1, "bp");
        drain_check(exp_bp, 1'b1, "bp");

        // 5a. Reset during SORT phase 3 (phases 0..2 done).
        load_block(blk_rev, 1'b0, "rst_sort");
        repeat (3) step();
        check_bit("rst_sort_busy_before", busy, 1'b1);
        apply_reset("rst_sort");

        // 5b. Reset during DRAIN after two outputs.
        load_block(blk_mix, 1'b0, "rst_drain");
        wait_out("rst_drain");
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_word($sformatf("rst_drain_out%0d", i), out_data, exp_mix[i]);
            step();
        end
        out_ready = 1'b0;
        check_bit("rst_drain_still_valid", out_valid, 1'b1);
        apply_reset("rst_drain");

        // 5c. Fresh block after the resets sorts with no stale words.
        load_block(blk_rev, 1'b0, "fresh");
        drain_check(exp_asc, 1'b0, "fresh");

        // 6. Back-to-back: second block offered during the first drain.
        load_block(blk_a, 1'b0, "b2b_a");
        wait_out("b2b_a");
        in_valid = 1'b1;
        in_data  = blk_b[0];
        drain_check(exp_a, 1'b0, "b2b_a");
        load_block(blk_b, 1'b0, "b2b_b");
        drain_check(exp_b, 1'b0, "b2b_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
